// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width; never below one bit so WIDTH=1 still has a counter.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full-adder cell, the additive twin of the subtractor cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell, registered carry, WIDTH+1 cycles per add.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, res, res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_cout;
    logic             accept, last_bit;

    full_adder u_fa (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands in res[0].
    generate
        if (WIDTH == 1) begin : g_res1
            assign res_next = fa_s;
        end else begin : g_resn
            assign res_next = {fa_s, res[WIDTH-1:1]};
        end
    endgenerate

    assign accept   = start && (state != RUN);
    assign last_bit = (state == RUN) && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            res   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_reg <= a_reg >> 1;
            b_reg <= b_reg >> 1;
            carry <= fa_cout;
            cnt   <= cnt + 1'b1;
            res   <= res_next;
            if (last_bit) begin
                sum  <= res_next;
                cout <= fa_cout;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: vector table plus hand-built multi-cycle sequences.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] prev_sum  = '0;
    logic         prev_cout = 1'b0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs [6];

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Present operands with start high and let the next edge (E0) capture them.
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called #1 after E0; walks E1..E8 and leaves the bench inside the DONE cycle.
    task automatic finish_check(input string nm, input logic [W-1:0] es, input logic ec);
        chk({nm, " busy@E0"}, busy, 1);
        for (int i = 1; i < W; i++) begin
            @(posedge clk); #1;
            chk({nm, " busy run"}, busy, 1);
            chk({nm, " done early"}, done, 0);
            chk({nm, " sum held"}, sum, prev_sum);
            chk({nm, " cout held"}, cout, prev_cout);
        end
        @(posedge clk); #1;
        chk({nm, " done"}, done, 1);
        chk({nm, " busy@done"}, busy, 0);
        chk({nm, " sum"}, sum, es);
        chk({nm, " cout"}, cout, ec);
        prev_sum = es;
        prev_cout = ec;
    endtask

    initial begin
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h01, 8'h01, 1'b1, 8'h03, 1'b0};
        vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

        // Reset state
        #12;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst sum", sum, 0);
        chk("rst cout", cout, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle busy", busy, 0);

        // Table-driven adds
        for (int v = 0; v < 6; v++) begin
            launch(vecs[v].a, vecs[v].b, vecs[v].cin);
            finish_check($sformatf("vec%0d", v), vecs[v].exp_sum, vecs[v].exp_cout);
            @(posedge clk); #1;
            chk($sformatf("vec%0d idle", v), done, 0);
            chk($sformatf("vec%0d idle busy", v), busy, 0);
        end

        // Reset mid-cycle while idle with a nonzero result held: clears immediately
        launch(8'h12, 8'h01, 1'b0);
        finish_check("pre-rst", 8'h13, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async rst sum", sum, 0);
        chk("async rst cout", cout, 0);
        chk("async rst done", done, 0);
        @(negedge clk); rst_n = 1'b1;
        prev_sum = '0; prev_cout = 1'b0;
        @(posedge clk); #1;

        // Start held through RUN with operands zeroed after capture
        begin
            int dcnt;
            dcnt = 0;
            a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
            @(posedge clk); #1;
            a = '0; b = '0; cin = 1'b1;
            for (int i = 1; i < W; i++) begin
                @(posedge clk); #1;
                if (done) dcnt++;
            end
            start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                if (done) begin
                    dcnt++;
                    chk("hold sum", sum, 8'h46);
                    chk("hold cout", cout, 0);
                end
            end
            chk("hold done pulses", dcnt, 1);
            chk("hold final sum", sum, 8'h46);
            prev_sum = 8'h46; prev_cout = 1'b0;
        end

        // Back-to-back: start accepted in the DONE cycle
        launch(8'h5A, 8'h3C, 1'b0);
        finish_check("b2b first", 8'h96, 1'b0);
        launch(8'h80, 8'h80, 1'b0);
        finish_check("b2b second", 8'h00, 1'b1);
        @(posedge clk); #1;
        chk("b2b idle", done, 0);

        // Reset at E4 of an in-flight add aborts it
        launch(8'h77, 8'h11, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort sum", sum, 0);
        chk("abort cout", cout, 0);
        begin
            int dcnt;
            dcnt = 0;
            repeat (2) begin
                @(posedge clk); #1;
                if (done) dcnt++;
            end
            @(negedge clk); rst_n = 1'b1;
            for (int i = 0; i < W + 2; i++) begin
                @(posedge clk); #1;
                if (done) dcnt++;
            end
            chk("abort no done", dcnt, 0);
        end
        prev_sum = '0; prev_cout = 1'b0;
        launch(8'h01, 8'h01, 1'b0);
        finish_check("post-abort", 8'h02, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
